tx_drv_ramp_ctrl: RTL

Sequencing controller for the serializer TX slice. It owns three things:
- the PRBS reset (rst_prbs);
- the 16:4 / 4:1 mux reset (rst_mux);
- the 6-bit output-driver strength codes (CTL_BUF_N / CTL_BUF_P) that feed the thermometer decoder.

On enable it releases the datapath resets in order, then ramps the driver codes one LSB per tick up to the programmed targets, so the output stage never sees large current steps. On disable it ramps the codes back down to 0 and re-asserts the resets.

---
 rtl/tx_ctrl_pkg.sv | 39 +++
 rtl/tx_ramp_tick.sv | 35 +++
 rtl/tx_drv_ramp_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the TX slice ramp controller.
//   tx_state_t  : controller sequencing states
//   CODE_W      : driver strength code width
//   CODE_MAX_DEF: default maximum legal driver code
//   clamp_code  : limits a requested code to the legal maximum
//   step_toward : moves a code one LSB toward a destination
package tx_ctrl_pkg;

  localparam int CODE_W       = 6;
  localparam int CODE_MAX_DEF = 40;

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    RAMP,
    ACTIVE,
    RAMP_DN
  } tx_state_t;

  function automatic logic [CODE_W-1:0] clamp_code(
    input logic [CODE_W-1:0] tgt,
    input logic [CODE_W-1:0] code_max
  );
    return (tgt > code_max) ? code_max : tgt;
  endfunction

  function automatic logic [CODE_W-1:0] step_toward(
    input logic [CODE_W-1:0] cur,
    input logic [CODE_W-1:0] dest
  );
    if (cur < dest)
      return cur + CODE_W'(1);
    else if (cur > dest)
      return cur - CODE_W'(1);
    else
      return cur;
  endfunction

endpackage

// File: rtl/tx_ramp_tick.sv
// Step-interval divider for the driver code ramp.
//   clk      : controller clock
//   rst      : synchronous active-high reset
//   clr      : clears the divider (ramp direction change)
//   run      : divider counts only while high; held at 0 otherwise
//   step_div : tick interval, one tick every step_div+1 cycles
//   tick     : high in the cycle the divider matches step_div
module tx_ramp_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] div;

  assign tick = run && (div == step_div);

  // Holding the divider at 0 while idle means every entry into a ramp
  // state starts from a cleared count without an explicit clear.
  // A step_div lowered below the current count wraps through 2^DIV_W.
  always_ff @(posedge clk) begin
    if (rst || clr || !run)
      div <= '0;
    else if (tick)
      div <= '0;
    else
      div <= div + DIV_W'(1);
  end

endmodule

// File: rtl/tx_drv_ramp_ctrl.sv
// Sequencing controller for the serializer TX slice: releases the PRBS and
// mux resets after a hold period, then ramps the output driver strength
// codes one LSB per tick toward the clamped targets; on disable ramps the
// codes to 0 and re-asserts the resets.
//   clk, rst          : clock, synchronous active-high reset
//   en                : slice enable (level)
//   tgt_n, tgt_p      : requested N/P driver codes
//   step_div          : ramp interval, one step every step_div+1 cycles
//   ctl_buf_n/p       : current driver codes
//   rst_prbs, rst_mux : datapath resets, active-high
//   busy              : sequencing in progress (RST_HOLD, RAMP, RAMP_DN)
//   ready             : codes settled at the clamped targets (ACTIVE)
module tx_drv_ramp_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int CODE_MAX = CODE_MAX_DEF,
  parameter int RST_CYC  = 16,
  parameter int DIV_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] tgt_n,
  input  logic [CODE_W-1:0] tgt_p,
  input  logic [DIV_W-1:0]  step_div,
  output logic [CODE_W-1:0] ctl_buf_n,
  output logic [CODE_W-1:0] ctl_buf_p,
  output logic              rst_prbs,
  output logic              rst_mux,
  output logic              busy,
  output logic              ready
);

  localparam int HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYC - 1);
  localparam logic [CODE_W-1:0] CODE_MAX_C = CODE_W'(CODE_MAX);

  tx_state_t         state;
  logic [HOLD_W-1:0] hold_cnt;

  logic [CODE_W-1:0] eff_n, eff_p;
  logic [CODE_W-1:0] dest_n, dest_p;
  logic [CODE_W-1:0] nxt_n, nxt_p;
  logic              at_tgt, at_zero, tgt_moved;
  logic              run, clr, tick;

  assign run = (state == RAMP) || (state == RAMP_DN);
  // Direction reversal restarts the step interval.
  assign clr = ((state == RAMP) && !en) || ((state == RAMP_DN) && en);

  tx_ramp_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .run      (run),
    .step_div (step_div),
    .tick     (tick)
  );

  always_comb begin
    eff_n     = clamp_code(tgt_n, CODE_MAX_C);
    eff_p     = clamp_code(tgt_p, CODE_MAX_C);
    dest_n    = (state == RAMP_DN) ? '0 : eff_n;
    dest_p    = (state == RAMP_DN) ? '0 : eff_p;
    nxt_n     = tick ? step_toward(ctl_buf_n, dest_n) : ctl_buf_n;
    nxt_p     = tick ? step_toward(ctl_buf_p, dest_p) : ctl_buf_p;
    // Completion is judged on the codes being written this edge so the
    // state change lands on the same edge as the final step.
    at_tgt    = (nxt_n == eff_n) && (nxt_p == eff_p);
    at_zero   = (nxt_n == '0) && (nxt_p == '0);
    tgt_moved = (eff_n != ctl_buf_n) || (eff_p != ctl_buf_p);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      ctl_buf_n <= '0;
      ctl_buf_p <= '0;
    end else begin
      // Codes only change on ticks, which occur only in the ramp states.
      ctl_buf_n <= nxt_n;
      ctl_buf_p <= nxt_p;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (en)
            state <= RST_HOLD;
        end
        RST_HOLD: begin
          if (!en)
            state <= IDLE;
          else if (hold_cnt == HOLD_LAST)
            state <= RAMP;
          else
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        RAMP: begin
          if (!en)
            state <= RAMP_DN;
          else if (at_tgt)
            state <= ACTIVE;
        end
        ACTIVE: begin
          if (!en)
            state <= RAMP_DN;
          else if (tgt_moved)
            state <= RAMP;
        end
        RAMP_DN: begin
          if (en)
            state <= RAMP;
          else if (at_zero)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the registered state; resets are held in IDLE and
  // RST_HOLD only.
  assign rst_prbs = (state == IDLE) || (state == RST_HOLD);
  assign rst_mux  = (state == IDLE) || (state == RST_HOLD);
  assign busy     = (state == RST_HOLD) || (state == RAMP) || (state == RAMP_DN);
  assign ready    = (state == ACTIVE);

endmodule
